stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter STACK_SIZE, default 20, stack depth in frames.
REQ-002 SHALL have parameter MACHINE_COUNT, default 10, joltage counters per target.
REQ-003 SHALL have parameter MAX_BUTTON_COUNT, default 13, combination field MSB index.
REQ-004 SHALL have parameter BITS_PER_JOLTAGE, default 9, bits per counter.
REQ-005 SHALL have parameter ANSWER_BIT_WIDTH, default 16, press-count width; FRAME_W = (MAX_BUTTON_COUNT+1) + MACHINE_COUNT*BITS_PER_JOLTAGE + 2*ANSWER_BIT_WIDTH.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port cmd_valid  input  1  command offered.
REQ-009 SHALL have port cmd_ready  output  1  command accepted when both high.
REQ-010 SHALL have port cmd_op  input  2  0 PUSH, 1 POP, 2 PEEK, 3 CLEAR.
REQ-011 SHALL have port cmd_frame  input  FRAME_W  {next_combination, target, min_button_press_count, button_press_count_for_call}, MSB first.
REQ-012 SHALL have port rsp_valid  output  1  response held until taken.
REQ-013 SHALL have port rsp_ready  input  1  response consumed when both high.
REQ-014 SHALL have port rsp_status  output  2  0 OK, 1 EMPTY, 2 FULL.
REQ-015 SHALL have port rsp_frame  output  FRAME_W  result frame, same packing.
REQ-016 SHALL have port stk_reset  output  1  active-high synchronous reset to stack.
REQ-017 SHALL have ports stk_push, stk_pop  output  1 each  single-cycle pulses to stack.
REQ-018 SHALL have port stk_frame  output  FRAME_W  push data to stack.
REQ-019 SHALL have ports stk_empty input 1, stk_top_frame input FRAME_W  stack top, valid one cycle after push/pop.
REQ-020 SHALL have port depth  output  clog2(STACK_SIZE+1)  current frame count.
REQ-021 SHALL have ports overflow_err, underflow_err  output  1 each  sticky error flags.

Function
REQ-022 SHALL run FSM INIT -> IDLE -> ISSUE -> WAIT -> RESP -> IDLE; INIT lasts one cycle with stk_reset=1.
REQ-023 SHALL drive cmd_ready=1 only in IDLE; accept latches cmd_op and cmd_frame, and for POP/PEEK latches stk_top_frame.
REQ-024 SHALL, in ISSUE, pulse stk_push (PUSH, depth<STACK_SIZE) or stk_pop (POP, depth>0) or stk_reset (CLEAR) for exactly one cycle, decoded from registered state; stk_frame = latched cmd_frame.
REQ-025 SHALL update depth at end of ISSUE: +1 on issued push, -1 on issued pop, 0 on CLEAR.
REQ-026 SHALL sample stk_top_frame at end of WAIT; rsp_valid rises 3 cycles after acceptance.
REQ-027 SHALL return rsp_frame: POP = frame latched at accept (popped frame); PUSH/PEEK = top sampled in WAIT; CLEAR = 0.
REQ-028 SHALL return FULL on PUSH at depth==STACK_SIZE, no push issued, overflow_err set.
REQ-029 SHALL return EMPTY on POP or PEEK at depth==0 with rsp_frame=0, no pop issued; POP also sets underflow_err.
REQ-030 SHALL hold rsp_valid/rsp_status/rsp_frame stable in RESP until rsp_ready; transfer returns to IDLE; no new command is accepted in the same cycle.
REQ-031 SHALL clear overflow_err/underflow_err only on CLEAR or reset.
REQ-032 SHALL never assert stk_push and stk_pop in the same cycle.

Reset
REQ-033 SHALL, while reset_n=0, force state INIT, stk_reset=1, cmd_ready=0, rsp_valid=0, rsp_status=0, rsp_frame=0, stk_push=0, stk_pop=0, depth=0, errors=0.
REQ-034 SHALL drop any in-flight command or unconsumed response on reset mid-operation.

Structure
REQ-035 SHALL take opcode, status and state encodings plus FRAME_W computation from a shared package stack_pkg.
REQ-036 SHALL be a single module with no sub-modules; stack instantiated beside it by the parent.

Verification
REQ-037 Reset release -> stk_reset high one cycle, cmd_ready high next, depth=0.
REQ-038 PUSH frame A then PEEK -> both OK, PEEK rsp_frame=A, depth=1, rsp_valid 3 cycles after each accept.
REQ-039 PUSH A, PUSH B, POP, POP -> POP responses B then A, depth 0, stk_empty=1.
REQ-040 STACK_SIZE=2: three PUSHes -> third FULL, no stk_push pulse, overflow_err=1; CLEAR -> flags 0, depth 0.
REQ-041 POP at depth 0 -> EMPTY, rsp_frame=0, underflow_err=1; rsp_ready held low 5 cycles -> response stable, cmd_ready=0.
REQ-042 reset_n low during WAIT of a PUSH -> rsp_valid never asserted, depth=0 after release.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared encodings for the stack sequencer: opcodes, response status, FSM states
// and the frame-width helper used by the sequencer and its parent.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'd0,
        OP_POP   = 2'd1,
        OP_PEEK  = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_EMPTY = 2'd1,
        ST_FULL  = 2'd2
    } status_e;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    // Frame layout, MSB first:
    // {next_combination, target, min_button_press_count, button_press_count_for_call}
    function automatic int calc_frame_w(
        input int max_button_count,
        input int machine_count,
        input int bits_per_joltage,
        input int answer_bit_width
    );
        return (max_button_count + 1)
             + machine_count * bits_per_joltage
             + 2 * answer_bit_width;
    endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Command front-end for an external frame stack: accepts PUSH/POP/PEEK/CLEAR,
// drives single-cycle stack strobes, tracks depth and returns one response per command.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter  int STACK_SIZE       = 20,
    parameter  int MACHINE_COUNT    = 10,
    parameter  int MAX_BUTTON_COUNT = 13,
    parameter  int BITS_PER_JOLTAGE = 9,
    parameter  int ANSWER_BIT_WIDTH = 16,
    localparam int FRAME_W = calc_frame_w(MAX_BUTTON_COUNT, MACHINE_COUNT,
                                          BITS_PER_JOLTAGE, ANSWER_BIT_WIDTH),
    localparam int DEPTH_W = $clog2(STACK_SIZE + 1)
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [FRAME_W-1:0] cmd_frame,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_status,
    output logic [FRAME_W-1:0] rsp_frame,

    output logic               stk_reset,
    output logic               stk_push,
    output logic               stk_pop,
    output logic [FRAME_W-1:0] stk_frame,
    input  logic               stk_empty,
    input  logic [FRAME_W-1:0] stk_top_frame,

    output logic [DEPTH_W-1:0] depth,
    output logic               overflow_err,
    output logic               underflow_err
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_SIZE);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    state_e               r_state;
    state_e               w_state_nxt;
    op_e                  r_op;
    logic [FRAME_W-1:0]   r_frame;
    status_e              r_status;
    logic [FRAME_W-1:0]   r_rsp_frame;
    logic [DEPTH_W-1:0]   r_depth;
    logic                 r_ovf;
    logic                 r_udf;

    op_e                  w_cmd_op;
    logic                 w_accept;
    logic                 w_issue;
    logic                 w_full;
    logic                 w_empty;
    logic [FRAME_W-1:0]   w_rsp_frame;

    assign w_cmd_op = op_e'(cmd_op);
    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    assign w_issue  = (r_state == S_ISSUE);
    assign w_full   = (r_depth == DEPTH_MAX);
    assign w_empty  = (r_depth == '0);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        stk_reset   = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;

        case (r_state)
            S_INIT: begin
                stk_reset   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Strobes decode only registered op/depth, so they are glitch-free single pulses.
                stk_push    = (r_op == OP_PUSH)  && !w_full;
                stk_pop     = (r_op == OP_POP)   && !w_empty;
                stk_reset   = (r_op == OP_CLEAR);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    // POP returns the frame captured at accept; PUSH/PEEK return the top seen after the stack settled.
    always_comb begin
        w_rsp_frame = '0;
        if (r_status != ST_EMPTY) begin
            case (r_op)
                OP_POP:   w_rsp_frame = r_frame;
                OP_PUSH,
                OP_PEEK:  w_rsp_frame = stk_empty ? '0 : stk_top_frame;
                OP_CLEAR: w_rsp_frame = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= OP_PUSH;
            r_frame     <= '0;
            r_status    <= ST_OK;
            r_rsp_frame <= '0;
            r_depth     <= '0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= w_cmd_op;
                r_frame <= ((w_cmd_op == OP_POP) || (w_cmd_op == OP_PEEK))
                           ? stk_top_frame : cmd_frame;
            end

            if (w_issue) begin
                case (r_op)
                    OP_PUSH: begin
                        if (w_full) begin
                            r_status <= ST_FULL;
                            r_ovf    <= 1'b1;
                        end else begin
                            r_status <= ST_OK;
                            r_depth  <= r_depth + DEPTH_ONE;
                        end
                    end
                    OP_POP: begin
                        if (w_empty) begin
                            r_status <= ST_EMPTY;
                            r_udf    <= 1'b1;
                        end else begin
                            r_status <= ST_OK;
                            r_depth  <= r_depth - DEPTH_ONE;
                        end
                    end
                    OP_PEEK: begin
                        r_status <= w_empty ? ST_EMPTY : ST_OK;
                    end
                    OP_CLEAR: begin
                        r_status <= ST_OK;
                        r_depth  <= '0;
                        r_ovf    <= 1'b0;
                        r_udf    <= 1'b0;
                    end
                endcase
            end

            if (r_state == S_WAIT) begin
                r_rsp_frame <= w_rsp_frame;
            end
        end
    end

    assign stk_frame     = r_frame;
    assign rsp_status    = r_status;
    assign rsp_frame     = r_rsp_frame;
    assign depth         = r_depth;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_udf;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed scenarios then random commands, checked against
// a queue-based model of stack semantics; a small behavioural stack sits beside the DUT.
module tb_stack_sequencer;
    import stack_pkg::*;

    localparam int TB_STACK_SIZE = 2;
    localparam int FRAME_W = calc_frame_w(13, 10, 9, 16);
    localparam int DEPTH_W = $clog2(TB_STACK_SIZE + 1);

    typedef logic [FRAME_W-1:0] frame_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    frame_t             cmd_frame;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_status;
    frame_t             rsp_frame;
    logic               stk_reset;
    logic               stk_push;
    logic               stk_pop;
    frame_t             stk_frame;
    logic               stk_empty;
    frame_t             stk_top_frame;
    logic [DEPTH_W-1:0] depth;
    logic               overflow_err;
    logic               underflow_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stack_sequencer #(
        .STACK_SIZE       (TB_STACK_SIZE),
        .MACHINE_COUNT    (10),
        .MAX_BUTTON_COUNT (13),
        .BITS_PER_JOLTAGE (9),
        .ANSWER_BIT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_frame     (cmd_frame),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_status    (rsp_status),
        .rsp_frame     (rsp_frame),
        .stk_reset     (stk_reset),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_frame     (stk_frame),
        .stk_empty     (stk_empty),
        .stk_top_frame (stk_top_frame),
        .depth         (depth),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    // Behavioural stack: top/empty reflect the state after the last clocked push/pop.
    frame_t stk_mem [0:TB_STACK_SIZE-1];
    int     stk_cnt = 0;

    always @(posedge clk) begin
        if (stk_reset) begin
            stk_cnt <= 0;
        end else if (stk_push && (stk_cnt < TB_STACK_SIZE)) begin
            stk_mem[stk_cnt] <= stk_frame;
            stk_cnt          <= stk_cnt + 1;
        end else if (stk_pop && (stk_cnt > 0)) begin
            stk_cnt <= stk_cnt - 1;
        end
    end

    assign stk_empty     = (stk_cnt == 0);
    assign stk_top_frame = (stk_cnt > 0) ? stk_mem[stk_cnt-1] : '0;

    int   push_pulses = 0;
    int   pop_pulses  = 0;
    logic both_seen   = 1'b0;

    always @(posedge clk) begin
        if (stk_push) push_pulses <= push_pulses + 1;
        if (stk_pop)  pop_pulses  <= pop_pulses + 1;
        if (stk_push && stk_pop) both_seen <= 1'b1;
    end

    // Reference model: plain LIFO plus sticky flags.
    frame_t m_q[$];
    logic   m_ovf = 1'b0;
    logic   m_udf = 1'b0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t rand_frame();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[FRAME_W-1:0];
    endfunction

    task automatic do_cmd(input logic [1:0] op, input frame_t f, input int hold);
        logic [1:0] exp_status;
        frame_t     exp_frame;
        int         exp_push;
        int         exp_pop;
        int         push0;
        int         pop0;
        int         n;
        logic [2:0] vseq;
        logic       hold_ok;
        logic [1:0] s0;
        frame_t     f0;

        exp_status = ST_OK;
        exp_frame  = '0;
        exp_push   = 0;
        exp_pop    = 0;
        case (op)
            2'd0: begin
                if (m_q.size() < TB_STACK_SIZE) begin
                    m_q.push_back(f);
                    exp_frame = f;
                    exp_push  = 1;
                end else begin
                    exp_status = ST_FULL;
                    exp_frame  = m_q[$];
                    m_ovf      = 1'b1;
                end
            end
            2'd1: begin
                if (m_q.size() > 0) begin
                    exp_frame = m_q.pop_back();
                    exp_pop   = 1;
                end else begin
                    exp_status = ST_EMPTY;
                    m_udf      = 1'b1;
                end
            end
            2'd2: begin
                if (m_q.size() > 0) exp_frame = m_q[$];
                else                exp_status = ST_EMPTY;
            end
            default: begin
                m_q.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        endcase

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_frame = f;
        n = 0;
        while ((cmd_ready !== 1'b1) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        push0 = push_pulses;
        pop0  = pop_pulses;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        vseq[2] = rsp_valid;
        @(negedge clk);
        vseq[1] = rsp_valid;
        @(negedge clk);
        vseq[0] = rsp_valid;
        check("rsp_latency", vseq, 3'b001);

        s0 = rsp_status;
        f0 = rsp_frame;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_status !== s0 || rsp_frame !== f0)
                hold_ok = 1'b0;
        end
        if (hold > 0) check("rsp_hold_stable", hold_ok, 1'b1);

        check("rsp_status", rsp_status, exp_status);
        check("rsp_frame", rsp_frame, exp_frame);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("back_to_idle", {rsp_valid, cmd_ready}, 2'b01);
        check("depth", depth, m_q.size());
        check("flags", {overflow_err, underflow_err}, {m_ovf, m_udf});
        check("stk_empty", stk_empty, (m_q.size() == 0));
        check("push_pulses", push_pulses - push0, exp_push);
        check("pop_pulses", pop_pulses - pop0, exp_pop);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        frame_t     fa;
        frame_t     fb;
        logic       saw_rsp;
        int         r;
        logic [1:0] op;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_frame = '0;
        rsp_ready = 1'b0;
        fa = rand_frame();
        fb = rand_frame();

        // Reset state and release.
        repeat (3) @(negedge clk);
        check("rst_outputs", {stk_reset, cmd_ready, rsp_valid, rsp_status, stk_push, stk_pop},
              {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0});
        check("rst_rsp_frame", rsp_frame, 0);
        check("rst_depth_flags", {depth, overflow_err, underflow_err}, 0);
        reset_n = 1'b1;
        #1;
        check("init_stk_reset", {stk_reset, cmd_ready}, 2'b10);
        @(negedge clk);
        check("idle_after_init", {stk_reset, cmd_ready}, 2'b01);
        check("idle_depth", depth, 0);

        // PUSH A then PEEK.
        do_cmd(2'd0, fa, 0);
        do_cmd(2'd2, rand_frame(), 1);

        // CLEAR, PUSH A, PUSH B, POP, POP.
        do_cmd(2'd3, rand_frame(), 0);
        do_cmd(2'd0, fa, 0);
        do_cmd(2'd0, fb, 0);
        do_cmd(2'd1, rand_frame(), 0);
        do_cmd(2'd1, rand_frame(), 0);

        // Overflow at capacity, then CLEAR.
        do_cmd(2'd0, rand_frame(), 0);
        do_cmd(2'd0, rand_frame(), 0);
        do_cmd(2'd0, rand_frame(), 2);
        do_cmd(2'd3, rand_frame(), 0);

        // Underflow with a stalled consumer, then PEEK on empty.
        do_cmd(2'd1, rand_frame(), 5);
        do_cmd(2'd2, rand_frame(), 0);

        // Reset while a PUSH is in WAIT.
        do_cmd(2'd3, rand_frame(), 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_frame = fa;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_outputs", {rsp_valid, cmd_ready, stk_reset, depth}, {1'b0, 1'b0, 1'b1, 2'b00});
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        check("midrst_no_rsp", saw_rsp, 1'b0);
        check("midrst_idle", {cmd_ready, depth, stk_empty}, {1'b1, 2'b00, 1'b1});

        // Random command mix.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      op = 2'd0;
            else if (r < 7) op = 2'd1;
            else if (r < 9) op = 2'd2;
            else            op = 2'd3;
            do_cmd(op, rand_frame(), $urandom_range(0, 2));
        end

        check("no_push_pop_overlap", both_seen, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
